// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the pipelined add/subtract unit.
//   - OP_* : two-bit operation encoding on the op port.
//   - op_inverts_b()  : 1 when operand B is bit-inverted (subtract modes).
//   - carry_in_sel()  : carry injected into segment 0 for a given op/cin.
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // A - B = A + ~B + 1, and A - B - cin = A + ~B + ~cin.
    function automatic logic carry_in_sel(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            OP_ADC:  c = cin;
            default: c = ~cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// ---------------------------------------------------------------------------
// adder_segment
//   Combinational SEG_W-bit ripple slice used by each pipeline stage.
//   Ports:
//     a_i, b_i  in  SEG_W  segment operands (B already conditioned)
//     cin_i     in  1      carry into bit 0 of the segment
//     s_o       out SEG_W  segment sum
//     cout_o    out 1      carry out of the segment MSB
//     c_msb_o   out 1      carry into the segment MSB
//     zero_o    out 1      s_o == 0
// ---------------------------------------------------------------------------
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_o,
    output logic             zero_o
);

    logic [SEG_W:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
    assign s_o     = full[SEG_W-1:0];
    assign cout_o  = full[SEG_W];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign c_msb_o = a_i[SEG_W-1] ^ b_i[SEG_W-1] ^ s_o[SEG_W-1];
    assign zero_o  = (s_o == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined ADD/SUB/ADC/SBB unit. The carry chain is cut into SEG_W-bit
//   segments, one per stage; STAGES = WIDTH/SEG_W register stages.
//   Ports:
//     clk, rst             clock (rising edge), async active-high reset
//     in_valid/in_ready    operand beat handshake
//     a, b, cin, op        operands, carry/borrow-in, op (00 ADD 01 SUB 10 ADC 11 SBB)
//     out_valid/out_ready  result beat handshake
//     sum, cout, ovf, zero, neg  registered result and flags
//
//   Handshake: a beat transfers on a rising edge where valid & ready are both
//   high. The whole pipe moves as one (advance = ~out_valid | out_ready);
//   in_ready equals advance, so nothing is captured while the output stalls,
//   and the output register holds its beat until it is taken.
// ---------------------------------------------------------------------------
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of SEG_W");
    end

    logic             advance;
    logic [WIDTH-1:0] b_prep;
    logic             c_prep;

    assign b_prep   = op_inverts_b(op) ? ~b : b;
    assign c_prep   = carry_in_sel(op, cin);
    assign in_ready = advance;

    // Stage k sums segment k. Operand bits not yet summed travel forward
    // right-aligned; the result grows by one segment per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = WIDTH - k * SEG_W;
        localparam int RES_W = (k + 1) * SEG_W;

        logic [IN_W-1:0]  op_a;
        logic [IN_W-1:0]  op_b;
        logic             carry_in;
        logic             zero_in;
        logic             valid_in;
        logic [SEG_W-1:0] seg_s;
        logic             seg_cout;
        logic             seg_cmsb;
        logic             seg_zero;
        logic [RES_W-1:0] s_d;
        logic [RES_W-1:0] s_q;
        logic             c_q;
        logic             z_d;
        logic             z_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign op_a     = a;
            assign op_b     = b_prep;
            assign carry_in = c_prep;
            assign zero_in  = 1'b1;
            assign valid_in = in_valid;
            assign s_d      = seg_s;
        end else begin : g_body
            assign op_a     = g_stage[k-1].g_fwd.a_q;
            assign op_b     = g_stage[k-1].g_fwd.b_q;
            assign carry_in = g_stage[k-1].c_q;
            assign zero_in  = g_stage[k-1].z_q;
            assign valid_in = g_stage[k-1].v_q;
            assign s_d      = {seg_s, g_stage[k-1].s_q};
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a_i     (op_a[SEG_W-1:0]),
            .b_i     (op_b[SEG_W-1:0]),
            .cin_i   (carry_in),
            .s_o     (seg_s),
            .cout_o  (seg_cout),
            .c_msb_o (seg_cmsb),
            .zero_o  (seg_zero)
        );

        assign z_d = zero_in & seg_zero;

        // Bubbles shift with the rest of the stage; only the valid bit says
        // whether the contents mean anything.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
                z_q <= 1'b0;
            end else if (advance) begin
                v_q <= valid_in;
                s_q <= s_d;
                c_q <= seg_cout;
                z_q <= z_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-SEG_W-1:0] a_q;
            logic [IN_W-SEG_W-1:0] b_q;
            logic                  unused_cmsb;

            // Only the top segment's MSB carry matters for signed overflow.
            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= op_a[IN_W-1:SEG_W];
                    b_q <= op_b[IN_W-1:SEG_W];
                end
            end
        end else begin : g_out
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = seg_cmsb ^ seg_cout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign advance   = ~g_stage[STAGES-1].v_q | out_ready;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign zero      = g_stage[STAGES-1].z_q;
    assign ovf       = g_stage[STAGES-1].g_out.ovf_q;
    assign neg       = sum[WIDTH-1];

endmodule
